// File: rtl/ec_flags_pkg.sv
// Shared definitions for the EC flag monitor: register word addresses and
// bit positions inside the STATUS and CTRL registers.
package ec_flags_pkg;

    // Register word addresses
    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_CAPTURE = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;
    localparam logic [2:0] ADDR_COUNT0  = 3'd4;
    localparam logic [2:0] ADDR_COUNT1  = 3'd5;
    localparam logic [2:0] ADDR_COUNT2  = 3'd6;
    localparam logic [2:0] ADDR_CTRL    = 3'd7;

    // CTRL register bits
    localparam int CTRL_COUNT_EN = 0;
    localparam int CTRL_CLR_CNT  = 1;

    // STATUS register bits
    localparam int STATUS_IRQ     = 0;
    localparam int STATUS_CNT_SAT = 1;

    // Number of counters visible through the register map
    localparam int NUM_CNT_ADDR = 3;

endpackage

// File: rtl/ec_flag_sync_edge.sv
// Multi-stage synchroniser for the asynchronous EC flag bus, followed by a
// one-cycle delay register used to detect 0->1 transitions per flag.
module ec_flag_sync_edge #(
    parameter int W      = 3,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync_out,
    output logic [W-1:0] flag_edge
);

    logic [STAGES*W-1:0] chain;
    logic [W-1:0]        prev;

    // Shift raw flags through the synchroniser; the top slice is the output stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[(STAGES-1)*W-1:0], din};
        end
    end

    assign sync_out = chain[STAGES*W-1 -: W];

    // Remember last cycle's synchronised value for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= sync_out;
        end
    end

    // Rising edges only; falling transitions are deliberately ignored
    assign flag_edge = sync_out & ~prev;

endmodule

// File: rtl/ec_flags_monitor.sv
// Avalon-MM slave monitoring the EC flag bus: live flags, sticky capture bits,
// maskable level interrupt and optional per-flag saturating event counters.
// Build option: define EC_FLAGS_COUNTERS_EN to include the counters, the
// saturation status bit and the CTRL register; otherwise addresses 4..7 read 0.
module ec_flags_monitor
    import ec_flags_pkg::*;
#(
    parameter int FLAG_W      = 3,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [FLAG_W-1:0] in_port,
    output logic              irq
);

    logic [FLAG_W-1:0] sync_out;
    logic [FLAG_W-1:0] flag_edge;
    logic [FLAG_W-1:0] mask;
    logic [FLAG_W-1:0] capture;
    logic [FLAG_W-1:0] cap_clr;
    logic              wr_mask;
    logic              any_sat;
    logic [31:0]       rd_next;
    logic              unused_wdata;

    // Only the low bits of writedata are meaningful
    assign unused_wdata = ^writedata;

    ec_flag_sync_edge #(
        .W      (FLAG_W),
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (in_port),
        .sync_out  (sync_out),
        .flag_edge (flag_edge)
    );

    assign wr_mask = write && (address == ADDR_MASK);
    assign cap_clr = (write && (address == ADDR_CAPTURE)) ? writedata[FLAG_W-1:0] : '0;

    // Interrupt enable mask, written by software
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= '0;
        end else if (wr_mask) begin
            mask <= writedata[FLAG_W-1:0];
        end
    end

    // Sticky capture bits: write-1-to-clear, a same-cycle edge wins over the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture <= '0;
        end else begin
            capture <= (capture & ~cap_clr) | flag_edge;
        end
    end

    // Level interrupt from registered capture and mask values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(capture & mask);
        end
    end

`ifdef EC_FLAGS_COUNTERS_EN
    logic                    wr_ctrl;
    logic                    clr_cnt;
    logic                    count_en;
    logic                    count_en_next;
    logic [FLAG_W*CNT_W-1:0] cnt_flat;
    logic [FLAG_W-1:0]       sat;
    logic [NUM_CNT_ADDR*CNT_W-1:0] cnt_view;

    assign wr_ctrl       = write && (address == ADDR_CTRL);
    assign clr_cnt       = wr_ctrl && writedata[CTRL_CLR_CNT];
    // A clear coincident with an edge honours the enable value being written
    assign count_en_next = wr_ctrl ? writedata[CTRL_COUNT_EN] : count_en;

    // Counter enable; CLR_CNT is a pulse and has no storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_en <= 1'b1;
        end else if (wr_ctrl) begin
            count_en <= writedata[CTRL_COUNT_EN];
        end
    end

    for (genvar i = 0; i < FLAG_W; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;

        // Saturating rising-edge counter for flag i
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
            end else if (clr_cnt) begin
                cnt <= (flag_edge[i] && count_en_next) ? CNT_W'(1) : '0;
            end else if (flag_edge[i] && count_en && !(&cnt)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign cnt_flat[i*CNT_W +: CNT_W] = cnt;
        assign sat[i]                     = &cnt;
    end

    // Map the first counters onto COUNT0..COUNT2; missing flags read 0
    for (genvar j = 0; j < NUM_CNT_ADDR; j++) begin : g_view
        if (j < FLAG_W) begin : g_on
            assign cnt_view[j*CNT_W +: CNT_W] = cnt_flat[j*CNT_W +: CNT_W];
        end else begin : g_off
            assign cnt_view[j*CNT_W +: CNT_W] = '0;
        end
    end

    assign any_sat = |sat;
`else
    assign any_sat = 1'b0;
`endif

    // Read mux; unused bits and unimplemented addresses read 0
    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[FLAG_W-1:0] = sync_out;
            ADDR_MASK:    rd_next[FLAG_W-1:0] = mask;
            ADDR_CAPTURE: rd_next[FLAG_W-1:0] = capture;
            ADDR_STATUS: begin
                rd_next[STATUS_IRQ]     = irq;
                rd_next[STATUS_CNT_SAT] = any_sat;
            end
`ifdef EC_FLAGS_COUNTERS_EN
            ADDR_COUNT0:  rd_next[CNT_W-1:0] = cnt_view[0 +: CNT_W];
            ADDR_COUNT1:  rd_next[CNT_W-1:0] = cnt_view[CNT_W +: CNT_W];
            ADDR_COUNT2:  rd_next[CNT_W-1:0] = cnt_view[2*CNT_W +: CNT_W];
            ADDR_CTRL:    rd_next[CTRL_COUNT_EN] = count_en;
`endif
            default: ;
        endcase
    end

    // Read data re-registered every cycle from the current address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_ec_flags_monitor.sv
// Scoreboard bench for ec_flags_monitor: reads push expected values into a
// queue, and a monitor compares readdata one cycle after each read is issued.
module tb_ec_flags_monitor;

`ifdef EC_FLAGS_COUNTERS_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    localparam int FLAG_W = 3;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              reset_n;
    logic [2:0]        address;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [FLAG_W-1:0] in_port;
    logic              irq;

    typedef struct {
        logic [31:0] exp;
        string       nm;
    } sb_t;

    sb_t  sbq[$];
    sb_t  mon_e;
    logic rd_issue   = 1'b0;
    logic rd_valid_q = 1'b0;
    int   total = 0;
    int   bad   = 0;

    ec_flags_monitor #(
        .FLAG_W      (FLAG_W),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A read issued before a rising edge has its data ready after that edge
    always @(posedge clk) rd_valid_q <= rd_issue;

    // Monitor: pop and compare on every cycle that carries read data
    always @(negedge clk) begin
        if (rd_valid_q) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: got 0x%08h with no expected entry", readdata);
            end else begin
                mon_e = sbq.pop_front();
                if (readdata !== mon_e.exp) begin
                    bad++;
                    $display("FAIL %s: got 0x%08h want 0x%08h", mon_e.nm, readdata, mon_e.exp);
                end
            end
        end
    end

    function automatic logic [31:0] ce(input logic [31:0] v);
        return HAS_CNT ? v : 32'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        @(negedge clk);
        address  = a;
        rd_issue = 1'b1;
        sbq.push_back('{exp: e, nm: nm});
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic toggle_flag1(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            in_port[1] = 1'b1;
            @(negedge clk);
            @(negedge clk);
            in_port[1] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int w;
        reset_n   = 1'b0;
        address   = 3'd0;
        write     = 1'b0;
        writedata = 32'd0;
        in_port   = '0;
        repeat (3) @(negedge clk);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_readdata", readdata, 32'd0);
        reset_n = 1'b1;

        // Register map after reset
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), (a == 7) ? ce(32'd1) : 32'd0, $sformatf("reset_addr%0d", a));
        end
        chk("reset_irq_after", {31'd0, irq}, 32'd0);

        // Rising edges on flags 0 and 2 with interrupts masked
        @(negedge clk);
        in_port = 3'b101;
        repeat (5) @(negedge clk);
        rd(3'd0, 32'h5, "data_101");
        rd(3'd2, 32'h5, "capture_101");
        rd(3'd4, ce(32'd1), "count0_first");
        rd(3'd5, 32'd0, "count1_none");
        rd(3'd6, ce(32'd1), "count2_first");
        rd(3'd3, 32'd0, "status_masked");
        chk("irq_masked", {31'd0, irq}, 32'd0);

        // Unmask flag2, then clear its capture bit
        wr(3'd1, 32'h4);
        repeat (2) @(negedge clk);
        chk("irq_unmasked", {31'd0, irq}, 32'd1);
        wr(3'd2, 32'h4);
        chk("irq_hold_after_clear", {31'd0, irq}, 32'd1);
        @(negedge clk);
        chk("irq_drop_after_clear", {31'd0, irq}, 32'd0);
        rd(3'd2, 32'h1, "capture_after_w1c");

        // Falling edge ignored; new edge on flag2 collides with its clear
        @(negedge clk);
        in_port = 3'b001;
        repeat (5) @(negedge clk);
        rd(3'd2, 32'h1, "capture_fall_ignored");
        @(negedge clk);
        in_port = 3'b101;
        @(negedge clk);
        wr(3'd2, 32'h4);
        repeat (3) @(negedge clk);
        rd(3'd2, 32'h5, "capture_set_wins");
        chk("irq_set_wins", {31'd0, irq}, 32'd1);
        wr(3'd2, 32'h7);
        repeat (2) @(negedge clk);
        rd(3'd2, 32'd0, "capture_all_cleared");
        chk("irq_all_cleared", {31'd0, irq}, 32'd0);

        // Saturate counter 1 (CNT_W=8 -> 0xFF)
        rd(3'd5, 32'd0, "count1_pre");
        toggle_flag1(300);
        repeat (5) @(negedge clk);
        rd(3'd5, ce(32'hFF), "count1_saturated");
        rd(3'd3, ce(32'h2), "status_saturated");
        rd(3'd2, 32'h2, "capture_flag1");
        chk("irq_flag1_masked", {31'd0, irq}, 32'd0);

        // Counter clear coincident with a flag0 edge, COUNT_EN kept at 1
        @(negedge clk);
        in_port = 3'b100;
        repeat (5) @(negedge clk);
        @(negedge clk);
        in_port = 3'b101;
        @(negedge clk);
        wr(3'd7, 32'h3);
        repeat (3) @(negedge clk);
        rd(3'd4, ce(32'd1), "clr_edge_count0");
        rd(3'd5, 32'd0, "clr_count1");
        rd(3'd6, 32'd0, "clr_count2");
        rd(3'd3, 32'd0, "status_after_clr");
        rd(3'd7, ce(32'd1), "ctrl_after_clr");
        rd(3'd2, 32'h3, "capture_after_clr");

        // Disable counting and clear: edges still capture, counts stay 0
        wr(3'd7, 32'h2);
        rd(3'd7, 32'd0, "ctrl_disabled");
        rd(3'd4, 32'd0, "count0_cleared");
        toggle_flag1(3);
        repeat (5) @(negedge clk);
        rd(3'd5, 32'd0, "count1_disabled");
        rd(3'd2, 32'h3, "capture_disabled");

        // Asynchronous reset with irq high and nonzero readdata
        wr(3'd1, 32'h7);
        repeat (2) @(negedge clk);
        chk("irq_before_reset", {31'd0, irq}, 32'd1);
        rd(3'd1, 32'h7, "mask_all");
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_irq", {31'd0, irq}, 32'd0);
        chk("async_reset_readdata", readdata, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Flags already high at reset release produce one edge each
        rd(3'd0, 32'h5, "data_after_reset");
        rd(3'd1, 32'd0, "mask_after_reset");
        rd(3'd2, 32'h5, "capture_after_reset");
        rd(3'd4, ce(32'd1), "count0_after_reset");
        rd(3'd7, ce(32'd1), "ctrl_after_reset");
        chk("irq_after_reset", {31'd0, irq}, 32'd0);

        // Drain the scoreboard within a bounded number of cycles
        w = 0;
        while (sbq.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: got %0d pending want 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ec_flags_monitor.md
# ec_flags_monitor

Avalon-MM slave controller for the 3-bit error-correction flag bus produced by the error-correcting arithmetic datapath. It synchronises the raw flags and detects rising edges into sticky capture bits. Maskable interrupts go to the Nios II, and per-flag event counts are kept so software can schedule scrub and retry decisions without polling. It replaces the plain read-only flag port in the Qsys system and sits between the datapath flag outputs and the system interconnect.

## Interface
- FLAG_W, 3, number of EC flag inputs (1..8)
- CNT_W, 16, width of each per-flag event counter (8..32)
- SYNC_STAGES, 2, synchroniser depth on in_port (2..3)

- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  3  register word address
- write  in  1  Avalon write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  FLAG_W  raw EC flags from datapath (asynchronous)
- irq  out  1  level interrupt, registered

## Operation
- Register map (word addresses):
  - 0 DATA (RO): synchronised live flags.
  - 1 MASK (RW): irq enable, one bit per flag.
  - 2 CAPTURE (RO, write-1-to-clear): sticky rising-edge bits.
  - 3 STATUS (RO): bit0 = irq, bit1 = any counter saturated.
  - 4..6 COUNT0..COUNT2 (RO): per-flag rising-edge counts, zero-extended.
  - 7 CTRL (RW): bit0 COUNT_EN; bit1 CLR_CNT, self-clearing and always reads 0.
- Addresses for flags ≥ FLAG_W, and unused bits, read 0. Writes to RO registers are ignored.
- Edge detection: sync_out is the last synchroniser stage; prev is sync_out delayed one cycle; edge = sync_out & ~prev. Falling edges are ignored.
- CAPTURE[i] set on edge[i]; cleared by writing 1 to address 2 bit i. If set and clear hit the same cycle, set wins.
- Counters:
  - Counter i increments on edge[i] when COUNT_EN=1.
  - Saturates at all-ones, no wrap.
  - Writing CTRL with bit1=1 zeroes all counters. If an edge hits the same cycle as the clear, that counter loads 1 when COUNT_EN=1 (post-write value); otherwise 0.
- irq register = |(CAPTURE & MASK), evaluated on register values.
- readdata is re-registered every cycle from address. There is no read strobe and reads have no side effects.

## Timing
- Reset values: readdata=0, irq=0, MASK=0, CAPTURE=0, counters=0, COUNT_EN=1. Synchroniser and prev registers reset to 0, so a flag already high at reset deassertion produces one edge.
- Read latency: 1 cycle. Address presented at edge k gives readdata valid after edge k+1.
- Write latency: register updated at the edge sampling write=1.
- Flag path, for in_port changing before edge k with SYNC_STAGES=2:
  - sync_out updates at k+1.
  - CAPTURE and counter update at k+2.
  - irq updates at k+3.
- Minimum detectable pulse: high for 1 clk in synchronous domain; asynchronous pulses shorter than 1 clk may be lost.
- Back-to-back edges on consecutive rising transitions each count, giving 1 count per 0→1 transition.
- Reset asserted mid-operation clears all state asynchronously. irq drops in the same reset assertion.

## Configuration
- EC_FLAGS_COUNTERS_EN defined:
  - Counters, STATUS bit1 and CTRL are implemented.
- EC_FLAGS_COUNTERS_EN undefined:
  - No counter logic is built.
  - Addresses 4..7 read 0 and writes there are ignored.
  - STATUS bit1 reads 0.
  - CAPTURE, MASK and irq are unchanged.

## Structure
- Shared package ec_flags_pkg:
  - Address localparams ADDR_DATA..ADDR_CTRL.
  - CTRL bit indices CTRL_COUNT_EN and CTRL_CLR_CNT.
  - STATUS bit indices.
- Sub-module ec_flag_sync_edge (parameters W, STAGES): synchroniser plus prev register; outputs sync_out and edge.
- Top: register file, counters (generate loop over FLAG_W), irq and read mux.

## Test plan
- Reset, then read all 8 addresses → all 0 except CTRL=0x1; irq=0.
- in_port 000→101 held, MASK=0 → CAPTURE=0x5 at k+2, DATA=0x5, COUNT0=1, COUNT2=1, irq stays 0.
- MASK=0x4, then write CAPTURE=0x4 → irq 1→0 one cycle after clear; CAPTURE=0x1. Repeat with an edge on flag2 in the clear cycle → CAPTURE bit2 stays 1.
- Toggle flag1 with 70000 rising edges, CNT_W=16 → COUNT1=0xFFFF, STATUS bit1=1.
- CTRL write 0x3 coincident with flag0 edge → COUNT0=1, others 0. CTRL write 0x2 → COUNT_EN=0; further edges set CAPTURE, counts stay 0.
- Assert reset_n low mid-burst with irq=1 → irq and readdata 0 immediately. Build without EC_FLAGS_COUNTERS_EN → addresses 4..7 read 0.
